// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: coin credit, N priced products with stock
// counters, inactivity refund, and coin-by-coin change over valid/ack handshakes.
module vend_ctrl_param #(
    parameter int NUM_ITEMS  = 4,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 200,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 5,
    parameter int TIMEOUT    = 1000
) (
    input  logic                            clk,
    input  logic                            clr,
    input  logic                            en,
    input  logic                            coin_nickel,
    input  logic                            coin_dime,
    input  logic                            coin_quarter,
    input  logic [NUM_ITEMS-1:0]            sel,
    input  logic                            purchase,
    input  logic                            cancel,
    input  logic                            restock,
    input  logic [NUM_ITEMS*CREDIT_W-1:0]   prices,
    input  logic                            vend_ack,
    input  logic                            coin_out_ack,
    output logic [CREDIT_W-1:0]             credit,
    output logic                            vend_valid,
    output logic [$clog2(NUM_ITEMS)-1:0]    vend_item,
    output logic                            coin_out_valid,
    output logic [1:0]                      coin_out_type,
    output logic                            coin_reject,
    output logic [1:0]                      err,
    output logic [NUM_ITEMS-1:0]            sold_out,
    output logic                            busy
);

    localparam int IDX_W = $clog2(NUM_ITEMS);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_CREDIT = 2'b01;
    localparam logic [1:0] ERR_SOLD   = 2'b10;
    localparam logic [1:0] ERR_SEL    = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

    state_t                 state_q, state_d;
    logic [CREDIT_W-1:0]    credit_q, credit_d;
    logic [1:0]             err_q, err_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [IDX_W-1:0]       vend_item_q, vend_item_d;
    logic                   vend_valid_q, coin_out_valid_q, coin_reject_q, coin_reject_d;
    logic [1:0]             coin_out_type_q;
    logic [STOCK_W-1:0]     stock_q [NUM_ITEMS];

    logic                   restock_take, dec_en, coin_take;
    logic                   coin_any, lower_rej, coin_fits;
    logic [CREDIT_W-1:0]    coin_val, price;
    logic [CREDIT_W:0]      sum;
    logic [IDX_W-1:0]       sel_idx;
    logic                   buy_ok;
    logic [1:0]             buy_err;

    function automatic logic [1:0] coin_for(input logic [CREDIT_W-1:0] c);
        if (c >= CREDIT_W'(25))      return 2'b11;
        else if (c >= CREDIT_W'(10)) return 2'b10;
        else if (c >= CREDIT_W'(5))  return 2'b01;
        else                         return 2'b00;
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] t);
        case (t)
            2'b11:   return CREDIT_W'(25);
            2'b10:   return CREDIT_W'(10);
            2'b01:   return CREDIT_W'(5);
            default: return '0;
        endcase
    endfunction

    // Highest-value coin wins a simultaneous drop; the rest are refused outright.
    always_comb begin
        coin_any  = coin_quarter | coin_dime | coin_nickel;
        lower_rej = (coin_quarter & (coin_dime | coin_nickel)) | (coin_dime & coin_nickel);
        if (coin_quarter)   coin_val = CREDIT_W'(25);
        else if (coin_dime) coin_val = CREDIT_W'(10);
        else if (coin_nickel) coin_val = CREDIT_W'(5);
        else                coin_val = '0;
        sum       = {1'b0, credit_q} + {1'b0, coin_val};
        coin_fits = sum <= (CREDIT_W + 1)'(MAX_CREDIT);
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel[i]) sel_idx = IDX_W'(i);
        end
        price   = prices[sel_idx*CREDIT_W +: CREDIT_W];
        buy_ok  = 1'b0;
        buy_err = ERR_OK;
        if (!$onehot(sel))                buy_err = ERR_SEL;
        else if (stock_q[sel_idx] == '0)  buy_err = ERR_SOLD;
        else if (credit_q < price)        buy_err = ERR_CREDIT;
        else                              buy_ok  = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        err_d        = err_q;
        tmr_d        = '0;
        vend_item_d  = vend_item_q;
        restock_take = 1'b0;
        dec_en       = 1'b0;
        coin_take    = 1'b0;
        case (state_q)
            S_IDLE: begin
                restock_take = restock;
                coin_take    = coin_any && coin_fits;
                if (coin_take) begin
                    credit_d = sum[CREDIT_W-1:0];
                    state_d  = S_CREDIT;
                    err_d    = ERR_OK;
                end
                if (purchase) err_d = ERR_CREDIT;
            end
            S_CREDIT: begin
                restock_take = restock;
                if (cancel) begin
                    state_d = S_CHANGE;
                    err_d   = ERR_OK;
                end else if (purchase && buy_ok) begin
                    credit_d    = credit_q - price;
                    dec_en      = 1'b1;
                    vend_item_d = sel_idx;
                    err_d       = ERR_OK;
                    state_d     = S_VEND;
                end else begin
                    coin_take = coin_any && coin_fits;
                    if (coin_take) begin
                        credit_d = sum[CREDIT_W-1:0];
                        err_d    = ERR_OK;
                    end
                    if (purchase) err_d = buy_err;
                    if (!(coin_take || purchase)) begin
                        tmr_d = tmr_q + 1'b1;
                        if (tmr_d >= TMR_W'(TIMEOUT)) state_d = S_CHANGE;
                    end
                end
            end
            S_VEND: begin
                if (vend_ack) state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                if (coin_out_ack) begin
                    credit_d = credit_q - coin_value(coin_out_type_q);
                    if (credit_d == '0) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A sub-nickel remainder (odd price) cannot be paid out and is forfeited.
        if (state_d == S_CHANGE && credit_d < CREDIT_W'(5)) begin
            state_d  = S_IDLE;
            credit_d = '0;
        end
        if (state_d == S_IDLE && state_q != S_IDLE) err_d = ERR_OK;
        coin_reject_d = lower_rej | (coin_any & ~coin_take);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q          <= S_IDLE;
            credit_q         <= '0;
            err_q            <= ERR_OK;
            tmr_q            <= '0;
            vend_item_q      <= '0;
            vend_valid_q     <= 1'b0;
            coin_out_valid_q <= 1'b0;
            coin_out_type_q  <= 2'b00;
            coin_reject_q    <= 1'b0;
        end else if (en) begin
            state_q          <= state_d;
            credit_q         <= credit_d;
            err_q            <= err_d;
            tmr_q            <= tmr_d;
            vend_item_q      <= vend_item_d;
            vend_valid_q     <= (state_d == S_VEND);
            coin_out_valid_q <= (state_d == S_CHANGE);
            coin_out_type_q  <= (state_d == S_CHANGE) ? coin_for(credit_d) : 2'b00;
            coin_reject_q    <= coin_reject_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_stock
            logic [STOCK_W-1:0] base_d, stock_d;
            always_comb begin
                base_d  = restock_take ? STOCK_W'(STOCK_INIT) : stock_q[gi];
                stock_d = base_d;
                if (dec_en && sel_idx == IDX_W'(gi) && base_d != '0) stock_d = base_d - 1'b1;
            end
            always_ff @(posedge clk or posedge clr) begin
                if (clr)     stock_q[gi] <= STOCK_W'(STOCK_INIT);
                else if (en) stock_q[gi] <= stock_d;
            end
            assign sold_out[gi] = (stock_q[gi] == '0);
        end
    endgenerate

    assign credit         = credit_q;
    assign vend_valid     = vend_valid_q;
    assign vend_item      = vend_item_q;
    assign coin_out_valid = coin_out_valid_q;
    assign coin_out_type  = coin_out_type_q;
    assign coin_reject    = coin_reject_q;
    assign err            = err_q;
    assign busy           = (state_q == S_VEND) || (state_q == S_CHANGE);

endmodule
